// File: rtl/dq_in_demux_pkg.sv
// Shared DQ PHY definitions: read-path FSM encoding and default bus geometry.
package dq_in_demux_pkg;

    localparam int DQ_DATA_WIDTH = 16;
    localparam int DQ_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

endpackage

// File: rtl/dq_in_demux_if.sv
// Word stream from the read deserializer toward the controller.
interface dq_in_demux_if
    import dq_in_demux_pkg::*;
#(
    parameter int DATA_WIDTH = DQ_DATA_WIDTH
);

    logic [DATA_WIDTH-1:0] dq_in_16;
    logic                  dq_in_16_valid;
    logic                  dq_in_16_ready;

    modport master (
        output dq_in_16,
        output dq_in_16_valid,
        input  dq_in_16_ready
    );

    modport slave (
        input  dq_in_16,
        input  dq_in_16_valid,
        output dq_in_16_ready
    );

endinterface

// File: rtl/dq_in_demux_fifo.sv
// First-word-fall-through word buffer; a push into a full buffer is taken
// only when a pop frees a slot in the same cycle.
module dq_in_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [DATA_WIDTH-1:0]      push_data,
    input  logic                       pop,
    output logic [DATA_WIDTH-1:0]      pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Head reads as zero when empty so the bus is clean after reset.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/dq_in_demux.sv
// DQ read-path deserializer: pairs rise/fall beats into words, buffers them
// and tracks a programmed burst length through to completion.
module dq_in_demux
    import dq_in_demux_pkg::*;
#(
    parameter int DATA_WIDTH = DQ_DATA_WIDTH,
    parameter int FIFO_DEPTH = DQ_FIFO_DEPTH,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [DATA_WIDTH/2-1:0] dq_in_rise,
    input  logic [DATA_WIDTH/2-1:0] dq_in_fall,
    input  logic                    dq_in_valid,
    input  logic                    rd_start,
    input  logic [LEN_WIDTH-1:0]    rd_len,
    output logic                    rd_busy,
    output logic                    rd_done,
    output logic                    overflow,
    dq_in_demux_if.master           dq_out
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    rd_state_e             state;
    logic [LEN_WIDTH-1:0]  beat_cnt;
    logic [DATA_WIDTH-1:0] cap_data;
    logic                  cap_valid;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic [CW-1:0]         count;
    logic                  drained;

    assign dq_out.dq_in_16_valid = ~empty;
    assign pop = dq_out.dq_in_16_valid & dq_out.dq_in_16_ready;

    // Burst is finished once nothing is in flight and the last word leaves.
    assign drained = ~cap_valid &
                     (empty | ((count == CW'(1)) & pop));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_valid <= 1'b0;
            cap_data  <= '0;
        end else begin
            cap_valid <= (state == ST_RECV) & dq_in_valid;
            if ((state == ST_RECV) && dq_in_valid) begin
                cap_data <= {dq_in_fall, dq_in_rise};
            end
        end
    end

    dq_in_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (cap_valid),
        .push_data (cap_data),
        .pop       (pop),
        .pop_data  (dq_out.dq_in_16),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            beat_cnt <= '0;
            rd_busy  <= 1'b0;
            rd_done  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            rd_done <= 1'b0;
            if (cap_valid && full && !pop) overflow <= 1'b1;
            unique case (state)
                ST_IDLE: begin
                    if (rd_start) begin
                        overflow <= 1'b0;
                        if (rd_len != '0) begin
                            beat_cnt <= rd_len;
                            state    <= ST_RECV;
                            rd_busy  <= 1'b1;
                        end else begin
                            rd_done <= 1'b1;
                        end
                    end
                end
                ST_RECV: begin
                    if (dq_in_valid) begin
                        beat_cnt <= beat_cnt - LEN_WIDTH'(1);
                        if (beat_cnt == LEN_WIDTH'(1)) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drained) begin
                        state   <= ST_IDLE;
                        rd_busy <= 1'b0;
                        rd_done <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    rd_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dq_in_demux.sv
// Directed and randomized bench for dq_in_demux with a queue-based model.
module tb_dq_in_demux;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] dq_in_rise;
    logic [7:0] dq_in_fall;
    logic       dq_in_valid;
    logic       rd_start;
    logic [7:0] rd_len;
    logic       rd_busy;
    logic       rd_done;
    logic       overflow;

    int errors = 0;
    int checks = 0;
    int pops   = 0;
    int dones  = 0;

    // Behavioural model state
    logic [15:0] mq[$];
    logic        busy_m;
    logic        done_m;
    logic        ov_m;
    logic        cap_v_m;
    logic [15:0] cap_m;
    int          left_m;

    dq_in_demux_if #(.DATA_WIDTH(16)) dq_if ();

    dq_in_demux #(
        .DATA_WIDTH (16),
        .FIFO_DEPTH (4),
        .LEN_WIDTH  (8)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .dq_in_rise  (dq_in_rise),
        .dq_in_fall  (dq_in_fall),
        .dq_in_valid (dq_in_valid),
        .rd_start    (rd_start),
        .rd_len      (rd_len),
        .rd_busy     (rd_busy),
        .rd_done     (rd_done),
        .overflow    (overflow),
        .dq_out      (dq_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        busy_m  = 1'b0;
        done_m  = 1'b0;
        ov_m    = 1'b0;
        cap_v_m = 1'b0;
        cap_m   = '0;
        left_m  = 0;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_busy"},  {31'd0, rd_busy}, 32'd0);
        chk({pfx, "_done"},  {31'd0, rd_done}, 32'd0);
        chk({pfx, "_valid"}, {31'd0, dq_if.dq_in_16_valid}, 32'd0);
        chk({pfx, "_ovf"},   {31'd0, overflow}, 32'd0);
        chk({pfx, "_data"},  {16'd0, dq_if.dq_in_16}, 32'd0);
    endtask

    // One clock: advance the model by the rules, then compare every output.
    task automatic tick();
        logic        pop_pre;
        logic        busy_pre;
        logic        cap_pre;
        logic [15:0] cap_w_pre;
        logic        in_v;
        logic [15:0] in_w;
        logic        st;
        int          ln;
        logic        done_n;
        pop_pre   = (mq.size() > 0) && dq_if.dq_in_16_ready;
        if (dq_if.dq_in_16_valid && dq_if.dq_in_16_ready) pops++;
        busy_pre  = busy_m;
        cap_pre   = cap_v_m;
        cap_w_pre = cap_m;
        in_v      = (left_m > 0) && dq_in_valid;
        in_w      = {dq_in_fall, dq_in_rise};
        st        = rd_start;
        ln        = int'(rd_len);
        @(posedge clk);
        #1;
        if (pop_pre) void'(mq.pop_front());
        if (cap_pre) begin
            if (mq.size() < 4) mq.push_back(cap_w_pre);
            else ov_m = 1'b1;
        end
        done_n  = busy_pre && (left_m == 0) && !cap_pre && (mq.size() == 0);
        cap_v_m = in_v;
        cap_m   = in_w;
        if (in_v) left_m--;
        done_m = done_n;
        if (done_n) busy_m = 1'b0;
        if (!busy_pre && st) begin
            ov_m = 1'b0;
            if (ln != 0) begin
                left_m = ln;
                busy_m = 1'b1;
            end else begin
                done_m = 1'b1;
            end
        end
        if (rd_done) dones++;
        chk("valid", {31'd0, dq_if.dq_in_16_valid}, {31'd0, mq.size() > 0});
        chk("data", {16'd0, dq_if.dq_in_16},
            {16'd0, (mq.size() > 0) ? mq[0] : 16'h0000});
        chk("busy", {31'd0, rd_busy}, {31'd0, busy_m});
        chk("done", {31'd0, rd_done}, {31'd0, done_m});
        chk("ovf",  {31'd0, overflow}, {31'd0, ov_m});
    endtask

    task automatic idle_inputs();
        dq_in_valid = 1'b0;
        rd_start    = 1'b0;
        rd_len      = '0;
    endtask

    task automatic start_burst(input int n);
        rd_start = 1'b1;
        rd_len   = 8'(n);
        tick();
        rd_start = 1'b0;
        rd_len   = '0;
    endtask

    task automatic pair(input logic [7:0] r, input logic [7:0] f);
        dq_in_rise  = r;
        dq_in_fall  = f;
        dq_in_valid = 1'b1;
        tick();
        dq_in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 100 && busy_m; i++) tick();
        chk(tag, {31'd0, rd_busy}, 32'd0);
        tick();
    endtask

    initial begin
        reset_n = 1'b0;
        dq_in_rise = '0;
        dq_in_fall = '0;
        dq_if.dq_in_16_ready = 1'b0;
        idle_inputs();
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        reset_n = 1'b1;
        tick();

        // Basic burst with ready held high
        dq_if.dq_in_16_ready = 1'b1;
        dones = 0;
        start_burst(4);
        for (int i = 0; i < 4; i++) begin
            dq_in_rise  = 8'h11 + 8'(i * 34);
            dq_in_fall  = 8'h22 + 8'(i * 34);
            dq_in_valid = 1'b1;
            tick();
            if (i == 1) chk("latency", {16'd0, dq_if.dq_in_16}, 32'h2211);
        end
        dq_in_valid = 1'b0;
        drain("basic_end");
        chk("basic_dones", dones, 1);
        chk("basic_ovf", {31'd0, overflow}, 32'd0);

        // Backpressure: six words into a four-entry buffer
        dq_if.dq_in_16_ready = 1'b0;
        dones = 0;
        start_burst(6);
        for (int i = 0; i < 6; i++) pair(8'hA0 + 8'(i), 8'hB0 + 8'(i));
        repeat (3) tick();
        chk("bp_ovf", {31'd0, overflow}, 32'd1);
        chk("bp_head", {16'd0, dq_if.dq_in_16}, 32'hB0A0);
        pops = 0;
        dq_if.dq_in_16_ready = 1'b1;
        drain("bp_end");
        chk("bp_pops", pops, 4);
        chk("bp_dones", dones, 1);

        // Full buffer with push and pop in the same cycle
        dq_if.dq_in_16_ready = 1'b0;
        start_burst(5);
        for (int i = 0; i < 4; i++) pair(8'h30 + 8'(i), 8'h40 + 8'(i));
        repeat (2) tick();
        pair(8'h3F, 8'h4F);
        pops = 0;
        dq_if.dq_in_16_ready = 1'b1;
        tick();
        chk("pp_ovf", {31'd0, overflow}, 32'd0);
        drain("pp_end");
        chk("pp_pops", pops, 5);

        // Zero length
        start_burst(0);
        chk("zero_done", {31'd0, rd_done}, 32'd1);
        chk("zero_busy", {31'd0, rd_busy}, 32'd0);
        tick();
        chk("zero_done2", {31'd0, rd_done}, 32'd0);

        // Idle beats and a second start during RECV are ignored
        for (int i = 0; i < 3; i++) pair(8'hE0 + 8'(i), 8'hF0 + 8'(i));
        chk("idle_nowr", {31'd0, dq_if.dq_in_16_valid}, 32'd0);
        pops = 0;
        dones = 0;
        start_burst(3);
        pair(8'h01, 8'h02);
        rd_start = 1'b1;
        rd_len   = 8'd7;
        pair(8'h03, 8'h04);
        rd_start = 1'b0;
        pair(8'h05, 8'h06);
        drain("ign_end");
        chk("ign_pops", pops, 3);
        chk("ign_dones", dones, 1);

        // Asynchronous reset in the middle of a burst
        dq_if.dq_in_16_ready = 1'b0;
        start_burst(4);
        pair(8'h55, 8'h66);
        pair(8'h77, 8'h88);
        tick();
        chk("mid_pre_valid", {31'd0, dq_if.dq_in_16_valid}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        model_clear();
        @(posedge clk);
        #1 reset_n = 1'b1;
        tick();
        dq_if.dq_in_16_ready = 1'b1;
        dones = 0;
        start_burst(2);
        pair(8'h9A, 8'hBC);
        pair(8'hDE, 8'hF0);
        drain("post_rst_end");
        chk("post_rst_dones", dones, 1);

        // Randomized bursts with gaps, backpressure and stray starts
        for (int b = 0; b < 20; b++) begin
            start_burst(int'($urandom_range(0, 9)));
            for (int c = 0; c < 300 && busy_m; c++) begin
                dq_in_rise  = 8'($urandom);
                dq_in_fall  = 8'($urandom);
                dq_in_valid = ($urandom_range(0, 9) < 7);
                dq_if.dq_in_16_ready = ($urandom_range(0, 9) < 6);
                rd_start = ($urandom_range(0, 9) == 0);
                rd_len   = 8'($urandom_range(1, 9));
                tick();
            end
            idle_inputs();
            dq_if.dq_in_16_ready = 1'b1;
            chk("rnd_idle", {31'd0, rd_busy}, 32'd0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
